prefetch_issue_queue: RTL and testbench
=======================================

Name: prefetch_issue_queue

Overview:
- Sits between two prefetch engines (candidate generators) and the lower-level cache prefetch port.
- Arbitrates the engines' candidate addresses and filters duplicate lines.
- Buffers accepted candidates in a small FIFO and issues them with a valid/ready handshake.
- Squashes queued candidates that a demand miss from the upper-level cache has already made redundant.

Parameters:
- ADDR_W, 64, address width.
- LINE_OFFSET, 6, log2 of cache line bytes; line = addr[ADDR_W-1:LINE_OFFSET].
- DEPTH, 8, queue entries; power of 2, ≥2.
- ISSUE_GAP, 0, idle cycles forced after each accepted issue (throttle).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- cand0_valid_i  in  1  engine 0 candidate valid.
- cand0_address_i  in  ADDR_W  engine 0 candidate address.
- cand1_valid_i  in  1  engine 1 candidate valid.
- cand1_address_i  in  ADDR_W  engine 1 candidate address.
- up_address_i  in  ADDR_W  upper-level cache access address.
- up_miss_i  in  1  upper-level access missed.
- up_valid_i  in  1  upper-level access valid (read|write).
- lo_ready_i  in  1  lower level accepts a prefetch this cycle.
- lo_prefetch_address_o  out  ADDR_W  issued prefetch address, line-aligned.
- lo_prefetch_valid_o  out  1  issued prefetch valid.
- q_count_o  out  $clog2(DEPTH)+1  occupied entries, live or dead.
- drop_count_o  out  16  saturating count of dropped candidates.

Behaviour:
- Reset (async): queue empty, all live bits 0, RR pointer = engine 0, gap counter 0.
- Reset values of outputs: lo_prefetch_valid_o=0, lo_prefetch_address_o=0, q_count_o=0, drop_count_o=0.
- Reset mid-operation discards all entries immediately; there is no drain.
- Arbitration (one enqueue per cycle):
  - One candidate valid: it wins.
  - Both valid: the RR pointer picks the winner; the pointer then points to the loser.
  - The pointer changes only on a two-way conflict.
  - The loser is dropped (drop_count+1). There is no back-pressure to the engines.
- Filtering: the winner is discarded silently (no count) if its line equals:
  - any live queue entry, including the head being issued this cycle; or
  - up_address_i's line when up_valid_i&up_miss_i in the same cycle.
- Enqueue:
  - A surviving winner is written at tail with live=1.
  - If the queue is full and no pop occurs this cycle, the winner is dropped (drop_count+1).
  - Full with a simultaneous pop: the winner is accepted and the count is unchanged.
- Issue:
  - lo_prefetch_valid_o = !empty & live[head] & (gap==0), combinational from registered state.
  - lo_prefetch_address_o = {line[head], LINE_OFFSET'b0} whenever not empty; 0 when empty.
  - Handshake = valid&lo_ready_i: pop head and load gap=ISSUE_GAP; gap decrements to 0.
- Squash:
  - When up_valid_i&up_miss_i, every live entry whose line matches up_address_i's line is cleared (live=0), effective next cycle.
  - A handshake on the head in the same cycle wins: the head is issued and popped.
  - A squashed head deasserts valid before acceptance; the lower level treats prefetch as a hint and tolerates this.
- Dead head (!live): popped in one cycle regardless of lo_ready_i and gap, never issued.
- Pointer and count rules:
  - Pointers wrap modulo DEPTH.
  - q_count_o = tail − head occupancy, updated each cycle by push/pop.
  - drop_count_o saturates at 16'hFFFF.
  - Two drops in one cycle (arbitration loss plus full) add 2.

Decomposition:
- prefetch_pkg holds:
  - ADDR_W and LINE_OFFSET defaults;
  - typedef line_t = logic[ADDR_W-LINE_OFFSET-1:0];
  - typedef struct packed {line_t line; logic live;} pfq_entry_t;
  - a function to_line(addr).
- Sub-module prefetch_cand_arbiter: 2-way round-robin, outputs grant, winner address and a loser-drop pulse.
- The queue, filtering and squash CAM stay in prefetch_issue_queue.

Test Plan:
- Reset, then cand0 0x1000 with lo_ready=0 → next cycle valid=1, address 0x1000, q_count=1; raise lo_ready → pop, q_count=0, valid=0.
- cand0=0x2000 and cand1=0x3000 simultaneously, twice (second time cand0=0x4000, cand1=0x5000) → 0x2000 then 0x5000 queued, drop_count=2, pointer back at engine 0.
- lo_ready=0; cand0 0x1040, then 0x1078 → q_count=1, output address 0x1040; cand0 0x1080 → q_count=2.
- lo_ready=0; 9 distinct lines 0x0,0x40..0x200 → q_count=8, drop_count=1; then lo_ready=1 with a new cand 0x400 → accepted, q_count stays 8.
- Queue holds 0x2000,0x2040, lo_ready=0; up_valid=1, up_miss=1, up_address=0x2010 → next cycle valid=0; head popped; then valid=1, address 0x2040, q_count=1.
- ISSUE_GAP=2, three queued, lo_ready=1 → issues spaced 3 cycles apart; assert rst_i mid-gap → all outputs 0 immediately.

Source files
------------

// File: rtl/prefetch_issue_queue_pkg.sv
// Shared line geometry, queue entry layout and address-to-line helper
// for the prefetch issue queue.
package prefetch_pkg;

  localparam int PFQ_ADDR_W      = 64;
  localparam int PFQ_LINE_OFFSET = 6;

  typedef logic [PFQ_ADDR_W-PFQ_LINE_OFFSET-1:0] line_t;

  typedef struct packed {
    line_t line;
    logic  live;
  } pfq_entry_t;

  function automatic line_t to_line(input logic [PFQ_ADDR_W-1:0] addr);
    return addr[PFQ_ADDR_W-1:PFQ_LINE_OFFSET];
  endfunction

endpackage

// File: rtl/prefetch_issue_queue_if.sv
// Candidate, upper-level snoop and lower-level issue signals of the
// prefetch issue queue; the queue itself is the slave side.
interface prefetch_issue_queue_if #(
  parameter int ADDR_W = prefetch_pkg::PFQ_ADDR_W,
  parameter int DEPTH  = 8
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              cand0_valid_i;
  logic [ADDR_W-1:0] cand0_address_i;
  logic              cand1_valid_i;
  logic [ADDR_W-1:0] cand1_address_i;
  logic [ADDR_W-1:0] up_address_i;
  logic              up_miss_i;
  logic              up_valid_i;
  logic              lo_ready_i;
  logic [ADDR_W-1:0] lo_prefetch_address_o;
  logic              lo_prefetch_valid_o;
  logic [CNT_W-1:0]  q_count_o;
  logic [15:0]       drop_count_o;

  modport master (
    output cand0_valid_i, cand0_address_i, cand1_valid_i, cand1_address_i,
    output up_address_i, up_miss_i, up_valid_i, lo_ready_i,
    input  lo_prefetch_address_o, lo_prefetch_valid_o, q_count_o, drop_count_o
  );

  modport slave (
    input  cand0_valid_i, cand0_address_i, cand1_valid_i, cand1_address_i,
    input  up_address_i, up_miss_i, up_valid_i, lo_ready_i,
    output lo_prefetch_address_o, lo_prefetch_valid_o, q_count_o, drop_count_o
  );

endinterface

// File: rtl/prefetch_issue_queue_arb.sv
// Two-way round-robin arbiter between the prefetch engines; the loser of a
// conflict is dropped, and the pointer then favours it on the next conflict.
module prefetch_cand_arbiter #(
  parameter int ADDR_W = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              c0_valid,
  input  logic [ADDR_W-1:0] c0_address,
  input  logic              c1_valid,
  input  logic [ADDR_W-1:0] c1_address,
  output logic [1:0]        grant,
  output logic [ADDR_W-1:0] win_address,
  output logic              lose_drop
);

  logic rr_q;
  logic conflict;

  always_comb begin
    conflict = c0_valid & c1_valid;
    if (conflict) grant = rr_q ? 2'b10 : 2'b01;
    else          grant = {c1_valid, c0_valid};
    win_address = grant[1] ? c1_address : c0_address;
    lose_drop   = conflict;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)         rr_q <= 1'b0;
    else if (conflict) rr_q <= ~rr_q;
  end

endmodule

// File: rtl/prefetch_issue_queue.sv
// Prefetch issue queue: arbitrates two engines, filters duplicate lines,
// buffers survivors in a FIFO with live bits and issues them downstream.
module prefetch_issue_queue
  import prefetch_pkg::*;
#(
  parameter int ADDR_W      = PFQ_ADDR_W,
  parameter int LINE_OFFSET = PFQ_LINE_OFFSET,
  parameter int DEPTH       = 8,
  parameter int ISSUE_GAP   = 0
) (
  input logic                   clk_i,
  input logic                   rst_i,
  prefetch_issue_queue_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int GAP_W = (ISSUE_GAP > 0) ? $clog2(ISSUE_GAP + 1) : 1;

  pfq_entry_t       entry_q [DEPTH];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;
  logic [GAP_W-1:0] gap_q;
  logic [15:0]      drop_q;

  logic [1:0]        grant;
  logic [ADDR_W-1:0] win_address;
  logic              lose_drop;

  prefetch_cand_arbiter #(.ADDR_W(ADDR_W)) u_arb (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .c0_valid    (bus.cand0_valid_i),
    .c0_address  (bus.cand0_address_i),
    .c1_valid    (bus.cand1_valid_i),
    .c1_address  (bus.cand1_address_i),
    .grant       (grant),
    .win_address (win_address),
    .lose_drop   (lose_drop)
  );

  logic        empty, full, head_live, issue_valid, handshake, pop;
  logic        win_valid, up_hit, dup, push, full_drop;
  line_t       win_line, up_line;
  logic [1:0]  drops;
  logic [16:0] drop_sum;

  always_comb begin
    empty       = (count_q == '0);
    full        = (count_q == CNT_W'(DEPTH));
    head_live   = entry_q[head_q].live;
    issue_valid = !empty && head_live && (gap_q == '0);
    handshake   = issue_valid && bus.lo_ready_i;
    // a dead head is retired immediately, independent of ready and throttle
    pop         = handshake || (!empty && !head_live);
    win_valid   = |grant;
    win_line    = to_line(win_address);
    up_line     = to_line(bus.up_address_i);
    up_hit      = bus.up_valid_i && bus.up_miss_i;
    // unoccupied slots always have live cleared, so scanning every slot is safe
    dup         = up_hit && (win_line == up_line);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (entry_q[i[PTR_W-1:0]].live && (entry_q[i[PTR_W-1:0]].line == win_line))
        dup = 1'b1;
    end
    push      = win_valid && !dup && (!full || pop);
    full_drop = win_valid && !dup && full && !pop;
    drops     = 2'(lose_drop) + 2'(full_drop);
    drop_sum  = {1'b0, drop_q} + 17'(drops);
  end

  assign bus.lo_prefetch_valid_o   = issue_valid;
  assign bus.lo_prefetch_address_o = empty ? '0
                                           : {entry_q[head_q].line, {LINE_OFFSET{1'b0}}};
  assign bus.q_count_o             = count_q;
  assign bus.drop_count_o          = drop_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) entry_q[i[PTR_W-1:0]] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      gap_q   <= '0;
      drop_q  <= '0;
    end else begin
      if (up_hit) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (entry_q[i[PTR_W-1:0]].line == up_line) entry_q[i[PTR_W-1:0]].live <= 1'b0;
        end
      end
      if (pop) begin
        entry_q[head_q].live <= 1'b0;
        head_q               <= head_q + PTR_W'(1);
      end
      // full-with-pop writes the slot being vacated; the push must win
      if (push) begin
        entry_q[tail_q] <= {win_line, 1'b1};
        tail_q          <= tail_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      if (handshake)          gap_q <= GAP_W'(ISSUE_GAP);
      else if (gap_q != '0)   gap_q <= gap_q - GAP_W'(1);
      drop_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

endmodule

// File: tb/tb_prefetch_issue_queue.sv
// Bench for prefetch_issue_queue: directed scenarios plus random traffic on
// two instances (no throttle, ISSUE_GAP=2) against a queue-based model.
module tb_prefetch_issue_queue;

  localparam int AW    = 64;
  localparam int DEPTH = 8;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  prefetch_issue_queue_if #(.ADDR_W(AW), .DEPTH(DEPTH)) bus0 ();
  prefetch_issue_queue_if #(.ADDR_W(AW), .DEPTH(DEPTH)) bus2 ();

  prefetch_issue_queue #(.ADDR_W(AW), .LINE_OFFSET(6), .DEPTH(DEPTH), .ISSUE_GAP(0)) dut0 (
    .clk_i(clk_i), .rst_i(rst_i), .bus(bus0));
  prefetch_issue_queue #(.ADDR_W(AW), .LINE_OFFSET(6), .DEPTH(DEPTH), .ISSUE_GAP(2)) dut2 (
    .clk_i(clk_i), .rst_i(rst_i), .bus(bus2));

  // stimulus shared by both instances
  logic          c0v, c1v, upv, upm, rdy;
  logic [AW-1:0] c0a, c1a, upa;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    longint unsigned line;
    bit              live;
  } ment_t;

  ment_t mq [2][$];
  int    mgap [2];
  bit    mrr  [2];
  int    mdrop[2];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic read_outs(input int d, output logic v, output logic [63:0] a,
                           output logic [3:0] c, output logic [15:0] dr);
    if (d == 0) begin
      v = bus0.lo_prefetch_valid_o; a = bus0.lo_prefetch_address_o;
      c = bus0.q_count_o;           dr = bus0.drop_count_o;
    end else begin
      v = bus2.lo_prefetch_valid_o; a = bus2.lo_prefetch_address_o;
      c = bus2.q_count_o;           dr = bus2.drop_count_o;
    end
  endtask

  task automatic probe(input int d, input string tag, input int what, input logic [63:0] exp);
    logic v; logic [63:0] a; logic [3:0] c; logic [15:0] dr;
    read_outs(d, v, a, c, dr);
    case (what)
      0:       check_eq(tag, 64'(v), exp);
      1:       check_eq(tag, a, exp);
      2:       check_eq(tag, 64'(c), exp);
      default: check_eq(tag, 64'(dr), exp);
    endcase
  endtask

  task automatic drive();
    bus0.cand0_valid_i = c0v; bus0.cand0_address_i = c0a;
    bus0.cand1_valid_i = c1v; bus0.cand1_address_i = c1a;
    bus0.up_valid_i = upv; bus0.up_miss_i = upm; bus0.up_address_i = upa;
    bus0.lo_ready_i = rdy;
    bus2.cand0_valid_i = c0v; bus2.cand0_address_i = c0a;
    bus2.cand1_valid_i = c1v; bus2.cand1_address_i = c1a;
    bus2.up_valid_i = upv; bus2.up_miss_i = upm; bus2.up_address_i = upa;
    bus2.lo_ready_i = rdy;
  endtask

  task automatic idle_inputs();
    c0v = 0; c1v = 0; upv = 0; upm = 0;
    c0a = '0; c1a = '0; upa = '0;
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      mq[d].delete();
      mgap[d] = 0; mrr[d] = 0; mdrop[d] = 0;
    end
  endtask

  task automatic check_model(input int d);
    logic v; logic [63:0] a; logic [3:0] c; logic [15:0] dr;
    bit ev; logic [63:0] ea;
    read_outs(d, v, a, c, dr);
    ev = (mq[d].size() > 0) && mq[d][0].live && (mgap[d] == 0);
    ea = (mq[d].size() > 0) ? (mq[d][0].line << 6) : 64'h0;
    check_eq($sformatf("dut%0d valid", d * 1), 64'(v), 64'(ev));
    check_eq($sformatf("dut%0d address", d), a, ea);
    check_eq($sformatf("dut%0d q_count", d), 64'(c), 64'(mq[d].size()));
    check_eq($sformatf("dut%0d drop_count", d), 64'(dr), 64'(mdrop[d]));
  endtask

  // one clock of the behavioural queue for instance d
  task automatic model_update(input int d);
    ment_t q[$]; ment_t nq[$]; ment_t e;
    int n, gp; bit ev, hs, dead, pop, have_w, dup, hit;
    longint unsigned wl, ul;
    q  = mq[d];
    n  = q.size();
    gp = (d == 0) ? 0 : 2;
    ev   = (n > 0) && q[0].live && (mgap[d] == 0);
    hs   = ev && rdy;
    dead = (n > 0) && !q[0].live;
    pop  = hs || dead;
    have_w = 1; wl = 0;
    if (c0v && c1v) begin
      wl = (mrr[d] ? c1a : c0a) >> 6;
      mdrop[d]++;
      mrr[d] = !mrr[d];
    end else if (c0v) wl = c0a >> 6;
    else if (c1v)     wl = c1a >> 6;
    else              have_w = 0;
    ul  = upa >> 6;
    hit = upv && upm;
    dup = hit && (wl == ul);
    foreach (q[k]) if (q[k].live && q[k].line == wl) dup = 1;
    if (have_w && !dup && n == DEPTH && !pop) mdrop[d]++;
    foreach (q[k]) begin
      e = q[k];
      if (hit && e.line == ul) e.live = 0;
      nq.push_back(e);
    end
    if (pop) void'(nq.pop_front());
    if (have_w && !dup && (n < DEPTH || pop)) begin
      e.line = wl; e.live = 1;
      nq.push_back(e);
    end
    mq[d] = nq;
    if (hs) mgap[d] = gp;
    else if (mgap[d] > 0) mgap[d]--;
    if (mdrop[d] > 65535) mdrop[d] = 65535;
  endtask

  task automatic cycle();
    drive();
    for (int d = 0; d < 2; d++) begin
      check_model(d);
      model_update(d);
    end
    @(posedge clk_i);
    #1;
  endtask

  // asynchronous reset: outputs must clear before any clock edge
  task automatic do_reset();
    rst_i = 1'b1;
    #2;
    for (int d = 0; d < 2; d++) begin
      probe(d, "reset valid", 0, 64'h0);
      probe(d, "reset address", 1, 64'h0);
      probe(d, "reset q_count", 2, 64'h0);
      probe(d, "reset drop_count", 3, 64'h0);
    end
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    model_clear();
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    a = (64'($urandom_range(0, 11)) << 6) | 64'($urandom_range(0, 63));
    if ($urandom_range(0, 7) == 0) a = a | (64'h1 << 40);
    return a;
  endfunction

  initial begin
    idle_inputs();
    rdy = 0;
    drive();
    model_clear();
    @(posedge clk_i);
    #1;
    do_reset();

    // single candidate, issue then pop
    c0v = 1; c0a = 64'h1000; cycle(); idle_inputs();
    probe(0, "first valid", 0, 64'h1);
    probe(0, "first address", 1, 64'h1000);
    probe(0, "first q_count", 2, 64'h1);
    rdy = 1; cycle(); rdy = 0;
    probe(0, "after pop q_count", 2, 64'h0);
    probe(0, "after pop valid", 0, 64'h0);

    // round-robin conflicts
    do_reset();
    c0v = 1; c1v = 1; c0a = 64'h2000; c1a = 64'h3000; cycle();
    c0a = 64'h4000; c1a = 64'h5000; cycle(); idle_inputs();
    probe(0, "rr q_count", 2, 64'h2);
    probe(0, "rr drop_count", 3, 64'h2);
    probe(0, "rr head", 1, 64'h2000);
    rdy = 1; cycle();
    probe(0, "rr second", 1, 64'h5000);
    cycle(); rdy = 0;
    c0v = 1; c1v = 1; c0a = 64'h6000; c1a = 64'h7000; cycle(); idle_inputs();
    probe(0, "rr back to engine0", 1, 64'h6000);
    probe(0, "rr drop_count 3", 3, 64'h3);

    // same-line duplicate filtered
    do_reset();
    c0v = 1; c0a = 64'h1040; cycle();
    c0a = 64'h1078; cycle(); idle_inputs();
    probe(0, "dup q_count", 2, 64'h1);
    probe(0, "dup address", 1, 64'h1040);
    c0v = 1; c0a = 64'h1080; cycle(); idle_inputs();
    probe(0, "next line q_count", 2, 64'h2);

    // full queue drop, then full with simultaneous pop
    do_reset();
    for (int i = 0; i < 9; i++) begin
      c0v = 1; c0a = 64'(i) * 64'h40; cycle();
    end
    idle_inputs();
    probe(0, "full q_count", 2, 64'h8);
    probe(0, "full drop_count", 3, 64'h1);
    rdy = 1; c0v = 1; c0a = 64'h400; cycle(); idle_inputs(); rdy = 0;
    probe(0, "full+pop q_count", 2, 64'h8);
    probe(0, "full+pop drop_count", 3, 64'h1);
    probe(0, "full+pop head", 1, 64'h40);

    // squash of the queued head by a demand miss
    do_reset();
    c0v = 1; c0a = 64'h2000; cycle();
    c0a = 64'h2040; cycle(); idle_inputs();
    upv = 1; upm = 1; upa = 64'h2010; cycle(); idle_inputs();
    probe(0, "squashed valid", 0, 64'h0);
    probe(0, "squashed q_count", 2, 64'h2);
    cycle();
    probe(0, "after dead pop valid", 0, 64'h1);
    probe(0, "after dead pop address", 1, 64'h2040);
    probe(0, "after dead pop q_count", 2, 64'h1);

    // issue throttle on the ISSUE_GAP=2 instance, then reset mid-gap
    do_reset();
    for (int i = 0; i < 3; i++) begin
      c0v = 1; c0a = 64'h100 + 64'(i) * 64'h40; cycle();
    end
    idle_inputs();
    rdy = 1;
    for (int k = 0; k < 7; k++) begin
      probe(1, $sformatf("gap valid k=%0d", k), 0, (k % 3 == 0) ? 64'h1 : 64'h0);
      cycle();
    end
    rdy = 0;
    c0v = 1; c1v = 1; c0a = 64'h200; c1a = 64'h240; cycle();
    c1v = 0; c0a = 64'h240; cycle(); idle_inputs();
    rdy = 1; cycle(); rdy = 0;
    probe(1, "mid-gap valid", 0, 64'h0);
    probe(1, "mid-gap q_count", 2, 64'h1);
    probe(1, "mid-gap drop_count", 3, 64'h1);
    #2;
    do_reset();

    // random traffic
    for (int cyc = 0; cyc < 4000; cyc++) begin
      c0v = ($urandom_range(0, 1) == 1); c0a = rand_addr();
      c1v = ($urandom_range(0, 2) == 0); c1a = rand_addr();
      upv = ($urandom_range(0, 2) == 0); upm = ($urandom_range(0, 1) == 1);
      upa = rand_addr();
      rdy = ((cyc / 500) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      cycle();
      if ($urandom_range(0, 699) == 0) begin
        idle_inputs();
        drive();
        do_reset();
      end
    end
    idle_inputs();
    cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
